// File: rtl/mmio_bus_mux_pkg.sv
// Shared definitions for the MMIO bus interconnect: FSM encoding and the
// field widths used to slice the flat per-region parameter vectors.
package mmio_bus_mux_pkg;

    localparam int WAIT_W = 4;
    localparam int LOG2_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_DATA   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/mmio_bus_mux_region_hit.sv
// Combinational decode for one slave region: size-aligned base compare and
// the address offset inside the region.
module mmio_region_hit #(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int                LOG2   = 8
) (
    input  logic [ADDR_W-1:0] address,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    // A region as large as the whole address space masks nothing off.
    localparam logic [ADDR_W-1:0] MASK =
        (LOG2 >= ADDR_W) ? {ADDR_W{1'b1}} : ADDR_W'((64'd1 << LOG2) - 64'd1);

    assign hit    = ((address >> LOG2) == (BASE >> LOG2));
    assign offset = address & MASK;

endmodule

// File: rtl/mmio_bus_mux.sv
// Memory-map interconnect between the CPU data port and N slave regions:
// decode, one-cycle slave strobe, per-region wait states, bus-error reporting.
module mmio_bus_mux
    import mmio_bus_mux_pkg::*;
#(
    parameter int                            N_REGIONS   = 4,
    parameter int                            ADDR_W      = 16,
    parameter int                            DATA_W      = 8,
    parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_BASE = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
    parameter logic [N_REGIONS*LOG2_W-1:0]   REGION_LOG2 = {5'd12, 5'd12, 5'd8, 5'd11},
    parameter logic [N_REGIONS*WAIT_W-1:0]   REGION_WAIT = {4'd2, 4'd1, 4'd0, 4'd0}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             din,
    input  logic                          w_en,
    input  logic                          r_en,
    output logic [DATA_W-1:0]             dout,
    output logic                          ready,
    output logic                          bus_err,
    output logic                          err_sticky,
    output logic [ADDR_W-1:0]             err_addr,
    input  logic                          err_clr,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_din,
    output logic [N_REGIONS-1:0]          s_w_en,
    output logic [N_REGIONS-1:0]          s_r_en,
    input  logic [N_REGIONS*DATA_W-1:0]   s_dout
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    state_t              state_q, state_d;
    logic [N_REGIONS-1:0] hits;
    logic [ADDR_W-1:0]   offsets [N_REGIONS];
    logic [IDX_W-1:0]    hit_idx, idx_q;
    logic [ADDR_W-1:0]   hit_offset;
    logic [N_REGIONS-1:0] hit_onehot;
    logic                mapped;
    logic                start;
    logic                op_wr_q;
    logic [WAIT_W-1:0]   wait_cnt;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
        mmio_region_hit #(
            .ADDR_W (ADDR_W),
            .BASE   (REGION_BASE[g*ADDR_W +: ADDR_W]),
            .LOG2   (int'(REGION_LOG2[g*LOG2_W +: LOG2_W]))
        ) u_hit (
            .address (address),
            .hit     (hits[g]),
            .offset  (offsets[g])
        );
    end

    // Scan downwards so the lowest-index overlapping region wins.
    always_comb begin
        hit_idx    = '0;
        hit_offset = '0;
        hit_onehot = '0;
        mapped     = 1'b0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_idx    = IDX_W'(i);
                hit_offset = offsets[i];
                hit_onehot = '0;
                hit_onehot[i] = 1'b1;
                mapped     = 1'b1;
            end
        end
    end

    assign start = (state_q == ST_IDLE) && (w_en || r_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_en || r_en) state_d = mapped ? ST_STROBE : ST_ERR;
            ST_STROBE: state_d = ST_DATA;
            ST_DATA:   if (wait_cnt == '0) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered on the request edge so slaves never see CPU-input glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wait_cnt <= '0;
            dout     <= '0;
            err_addr <= '0;
            s_addr   <= '0;
            s_din    <= '0;
            s_w_en   <= '0;
            s_r_en   <= '0;
        end else begin
            s_w_en <= '0;
            s_r_en <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_wr_q <= w_en;
                        idx_q   <= hit_idx;
                        if (mapped) begin
                            s_addr <= hit_offset;
                            s_din  <= din;
                            if (w_en) s_w_en <= hit_onehot;
                            else      s_r_en <= hit_onehot;
                        end else begin
                            err_addr <= address;
                            if (!w_en) dout <= '0;
                        end
                    end
                end
                ST_STROBE: wait_cnt <= REGION_WAIT[idx_q*WAIT_W +: WAIT_W];
                ST_DATA: begin
                    if (wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;
                    else if (!op_wr_q)   dout <= s_dout[idx_q*DATA_W +: DATA_W];
                end
                default: ;
            endcase
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  err_sticky <= 1'b0;
        else if (start && !mapped) err_sticky <= 1'b1;
        else if (err_clr)         err_sticky <= 1'b0;
    end

    assign ready   = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign bus_err = (state_q == ST_ERR);

endmodule

// File: tb/tb_mmio_bus_mux.sv
// Directed bench for mmio_bus_mux: timing of strobes/ready, wait states,
// bus-error reporting, request arbitration and asynchronous reset abort.
module tb_mmio_bus_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic [7:0]  din;
    logic        w_en, r_en, err_clr;
    logic [7:0]  dout;
    logic        ready, bus_err, err_sticky;
    logic [15:0] err_addr, s_addr;
    logic [7:0]  s_din;
    logic [3:0]  s_w_en, s_r_en;
    logic [31:0] s_dout;

    int checks = 0;
    int errors = 0;

    mmio_bus_mux dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .din        (din),
        .w_en       (w_en),
        .r_en       (r_en),
        .dout       (dout),
        .ready      (ready),
        .bus_err    (bus_err),
        .err_sticky (err_sticky),
        .err_addr   (err_addr),
        .err_clr    (err_clr),
        .s_addr     (s_addr),
        .s_din      (s_din),
        .s_w_en     (s_w_en),
        .s_r_en     (s_r_en),
        .s_dout     (s_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, bus_err, err_sticky, s_w_en, s_r_en} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {ready, bus_err, err_sticky, s_w_en, s_r_en});
        end
        checks++;
        if ({dout, err_addr, s_addr, s_din} !== 48'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {dout, err_addr, s_addr, s_din});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_region0();
        address = 16'h0005; r_en = 1'b1;
        @(negedge clk); r_en = 1'b0;
        checks++;
        if (s_r_en !== 4'b0001 || s_w_en !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rd0_c1 got r=%b w=%b rdy=%b exp r=0001 w=0000 rdy=0", s_r_en, s_w_en, ready);
        end
        @(negedge clk);
        checks++;
        if (s_r_en !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rd0_c2 got r=%b rdy=%b exp r=0000 rdy=0", s_r_en, ready);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || dout !== 8'hA5 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rd0_c3 got rdy=%b dout=%h err=%b exp rdy=1 dout=a5 err=0", ready, dout, bus_err);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL rd0_c4 got rdy=%b exp 0", ready);
        end
    endtask

    task automatic test_write_region1();
        address = 16'h1003; din = 8'h3C; w_en = 1'b1;
        @(negedge clk); w_en = 1'b0;
        checks++;
        if (s_w_en !== 4'b0010 || s_r_en !== 4'b0000 || s_addr !== 16'h0003 || s_din !== 8'h3C) begin
            errors++;
            $display("FAIL wr1_c1 got w=%b r=%b a=%h d=%h exp w=0010 r=0000 a=0003 d=3c",
                     s_w_en, s_r_en, s_addr, s_din);
        end
        @(negedge clk);
        checks++;
        if (s_w_en !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL wr1_c2 got w=%b rdy=%b exp w=0000 rdy=0", s_w_en, ready);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || dout !== 8'hA5) begin
            errors++;
            $display("FAIL wr1_c3 got rdy=%b dout=%h exp rdy=1 dout=a5", ready, dout);
        end
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        logic [15:0] t_addr [2];
        logic [15:0] t_off  [2];
        logic [3:0]  t_oh   [2];
        logic [7:0]  t_data [2];
        int          t_rdy  [2];
        t_addr = '{16'h2ABC, 16'h3010};
        t_off  = '{16'h0ABC, 16'h0010};
        t_oh   = '{4'b0100, 4'b1000};
        t_data = '{8'hC3, 8'h77};
        t_rdy  = '{4, 5};
        for (int t = 0; t < 2; t++) begin
            address = t_addr[t]; r_en = 1'b1;
            for (int c = 1; c <= t_rdy[t] + 1; c++) begin
                @(negedge clk); r_en = 1'b0;
                checks++;
                if (s_r_en !== ((c == 1) ? t_oh[t] : 4'b0000)) begin
                    errors++;
                    $display("FAIL ws%0d_strobe c=%0d got %b exp %b", t, c, s_r_en,
                             (c == 1) ? t_oh[t] : 4'b0000);
                end
                checks++;
                if (ready !== (c == t_rdy[t])) begin
                    errors++;
                    $display("FAIL ws%0d_ready c=%0d got %b exp %b", t, c, ready, c == t_rdy[t]);
                end
                if (c == 1) begin
                    checks++;
                    if (s_addr !== t_off[t]) begin
                        errors++;
                        $display("FAIL ws%0d_offset got %h exp %h", t, s_addr, t_off[t]);
                    end
                end
                if (c == t_rdy[t]) begin
                    checks++;
                    if (dout !== t_data[t]) begin
                        errors++;
                        $display("FAIL ws%0d_dout got %h exp %h", t, dout, t_data[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_bus_error();
        address = 16'h8000; r_en = 1'b1;
        @(negedge clk); r_en = 1'b0;
        checks++;
        if (ready !== 1'b1 || bus_err !== 1'b1 || dout !== 8'h00 || s_r_en !== 4'b0 || s_w_en !== 4'b0) begin
            errors++;
            $display("FAIL err_c1 got rdy=%b err=%b dout=%h r=%b w=%b exp 1 1 00 0000 0000",
                     ready, bus_err, dout, s_r_en, s_w_en);
        end
        checks++;
        if (err_addr !== 16'h8000 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_regs got addr=%h sticky=%b exp 8000 1", err_addr, err_sticky);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || bus_err !== 1'b0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_c2 got rdy=%b err=%b sticky=%b exp 0 0 1", ready, bus_err, err_sticky);
        end
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b exp 0", err_sticky);
        end
        address = 16'h9000; din = 8'h44; w_en = 1'b1; err_clr = 1'b1;
        @(negedge clk); w_en = 1'b0; err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b1 || err_addr !== 16'h9000 || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins got sticky=%b addr=%h err=%b exp 1 9000 1",
                     err_sticky, err_addr, bus_err);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        address = 16'h0010; din = 8'h5A; w_en = 1'b1; r_en = 1'b1;
        @(negedge clk); w_en = 1'b0; r_en = 1'b0;
        checks++;
        if (s_w_en !== 4'b0001 || s_r_en !== 4'b0000 || s_addr !== 16'h0010 || s_din !== 8'h5A) begin
            errors++;
            $display("FAIL dual_c1 got w=%b r=%b a=%h d=%h exp 0001 0000 0010 5a",
                     s_w_en, s_r_en, s_addr, s_din);
        end
        @(negedge clk);
        address = 16'h2000; r_en = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || dout !== 8'h00) begin
            errors++;
            $display("FAIL dual_c3 got rdy=%b dout=%h exp 1 00", ready, dout);
        end
        r_en = 1'b0;
        for (int c = 4; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (s_r_en !== 4'b0000 || s_w_en !== 4'b0000 || ready !== 1'b0) begin
                errors++;
                $display("FAIL ignored_req c=%0d got r=%b w=%b rdy=%b exp 0000 0000 0",
                         c, s_r_en, s_w_en, ready);
            end
        end
    endtask

    task automatic test_reset_abort();
        address = 16'h3020; r_en = 1'b1;
        @(negedge clk); r_en = 1'b0;
        checks++;
        if (s_r_en !== 4'b1000) begin
            errors++;
            $display("FAIL abort_strobe got %b exp 1000", s_r_en);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, bus_err, err_sticky, s_w_en, s_r_en} !== 11'd0 ||
            {dout, err_addr, s_addr, s_din} !== 48'd0) begin
            errors++;
            $display("FAIL abort_reset got ctrl=%b data=%h exp 0 0",
                     {ready, bus_err, err_sticky, s_w_en, s_r_en}, {dout, err_addr, s_addr, s_din});
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || s_r_en !== 4'b0000) begin
                errors++;
                $display("FAIL abort_quiet c=%0d got rdy=%b r=%b exp 0 0000", c, ready, s_r_en);
            end
        end
    endtask

    initial begin
        rst = 1'b1; address = '0; din = '0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
        s_dout = {8'h77, 8'hC3, 8'h11, 8'hA5};
        @(negedge clk);
        test_reset();
        test_read_region0();
        test_write_region1();
        test_wait_states();
        test_bus_error();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
